logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
- Parametrised, two-stage pipelined bitwise logic unit. It generalises the fixed 32-bit two-input gate modules (NOR/AND/OR/INV/BUF) into one WIDTH-bit block with an op-select input.
- It adds valid/ready flow control with full-throughput backpressure and a completed-operation counter.
- It sits between the operand-fetch and writeback stages of the datapath, as the logic-class execution unit beside the adder/shifter.

Parameters:
- WIDTH, 32, operand/result bit width (>=1).
- CNT_WIDTH, 16, width of the completed-operation counter (>=1).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operand set on A/B/OP is valid.
- IN_READY  output  1  unit can accept an operand set this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B (ignored for INV/BUF).
- OP  input  3  operation select.
- OUT_VALID  output  1  Y holds a valid result.
- OUT_READY  input  1  consumer accepts Y this cycle.
- Y  output  WIDTH  result.
- OP_CNT  output  CNT_WIDTH  count of results accepted by the consumer.

Behaviour:
- Reset (RST=0, asynchronous): all valid flags, stage registers, Y and OP_CNT are cleared to 0. IN_READY reads 1 once both stages are empty. Any in-flight operations are discarded; none are replayed after reset.
- OP encoding, bitwise over WIDTH:
  - 000 AND: A&B
  - 001 OR: A|B
  - 010 NOR: ~(A|B)
  - 011 INV: ~A
  - 100 BUF: A
  - 101 XOR: A^B
  - 110 NAND: ~(A&B)
  - 111 XNOR: ~(A^B)
- Stage 1 (S1) registers A, B, OP and valid v1. Stage 2 (S2) registers the computed result into Y and valid v2, with OUT_VALID=v2.
- Advance rules, all evaluated in the same cycle:
  - adv2 = v1 & (~v2 | OUT_READY)
  - IN_READY = ~v1 | adv2 (combinational from state and OUT_READY; no combinational path from IN_VALID)
  - in_fire = IN_VALID & IN_READY
  - out_fire = OUT_VALID & OUT_READY
- S1 update: if in_fire, load A/B/OP and set v1=1. Else if adv2, set v1=0.
- S2 update: if adv2, load result and set v2=1. Else if out_fire, set v2=0.
- Latency: 2 cycles from in_fire to OUT_VALID, with the consumer always ready. Throughput is 1 result per cycle.
- Backpressure: while OUT_VALID=1 and OUT_READY=0, Y and OUT_VALID hold stable. S1 may still fill (one more operand set). When both stages are full, IN_READY=0.
- Simultaneous out_fire and adv2: S2 is replaced by the new result; v2 stays 1.
- Simultaneous in_fire and adv2: S1 is replaced; v1 stays 1.
- Operands with IN_VALID=0 are never captured. OP/A/B only need to be stable during in_fire.
- OP_CNT increments by 1 on each out_fire and wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Y is don't-care-free: it holds its last value when OUT_VALID=0. It is never X after reset.

Optional Feature:
- Macro: LOGIC_UNIT_FLAGS_EN.
- Defined: adds outputs ZERO (1 bit, result==0) and ONES (1 bit, result all 1s). Both are registered in S2 alongside Y, share OUT_VALID, reset to 0, and hold under backpressure.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: RST=0 mid-stream with both stages full -> on the same edge, OUT_VALID=0, Y=0, OP_CNT=0. After release, IN_READY=1.
- All ops, WIDTH=32, OUT_READY=1: A=0xF0F0_1234, B=0x0FF0_FFFF, OP=0..7 on consecutive cycles -> results arrive 2 cycles later, one per cycle: AND 0x00F0_1234, OR 0xFFF0_FFFF, NOR 0x000F_0000, INV 0x0F0F_EDCB, BUF 0xF0F0_1234, XOR 0xFF00_EDCB, NAND 0xFF0F_EDCB, XNOR 0x00FF_1234. OP_CNT=8.
- Backpressure: stream 4 ops with OUT_READY=0 -> IN_READY drops after 2 accepted, Y is stable at the first result. Release OUT_READY -> results drain in order, the remaining 2 are accepted, and there is no loss or duplication.
- Counter wrap: CNT_WIDTH=4, 17 accepted results -> OP_CNT=1.
- Parametrisation: WIDTH=1 and WIDTH=64 with random A/B/OP and a random OUT_READY pattern -> the scoreboard matches the reference bitwise model and order.
- Flags (LOGIC_UNIT_FLAGS_EN): AND with A=0xFFFF_0000, B=0x0000_FFFF -> ZERO=1, ONES=0. NOR with A=B=0 -> ZERO=0, ONES=1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit bitwise logic unit with valid/ready flow control and a completed-op counter.
// Optional macro LOGIC_UNIT_FLAGS_EN adds registered ZERO/ONES result flags.
module logic_unit_pipe #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           OP,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WIDTH-1:0]     Y,
  output logic [CNT_WIDTH-1:0] OP_CNT
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic                 ZERO,
  output logic                 ONES
`endif
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_INV  = 3'b011;
  localparam logic [2:0] OP_BUF  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NAND = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  logic                 v1_q, v1_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic                 v2_q, v2_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic             adv2;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] result;

  // S1 may drain into S2 whenever S2 is empty or being consumed this cycle.
  assign adv2     = v1_q & (~v2_q | OUT_READY);
  assign IN_READY = ~v1_q | adv2;
  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = v2_q & OUT_READY;

  always_comb begin
    result = '0;
    case (op_q)
      OP_AND:  result = a_q & b_q;
      OP_OR:   result = a_q | b_q;
      OP_NOR:  result = ~(a_q | b_q);
      OP_INV:  result = ~a_q;
      OP_BUF:  result = a_q;
      OP_XOR:  result = a_q ^ b_q;
      OP_NAND: result = ~(a_q & b_q);
      OP_XNOR: result = ~(a_q ^ b_q);
      default: result = '0;
    endcase
  end

  always_comb begin
    v1_d  = v1_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    v2_d  = v2_q;
    y_d   = y_q;
    cnt_d = cnt_q;

    if (in_fire) begin
      v1_d = 1'b1;
      a_d  = A;
      b_d  = B;
      op_d = OP;
    end else if (adv2) begin
      v1_d = 1'b0;
    end

    if (adv2) begin
      v2_d = 1'b1;
      y_d  = result;
    end else if (out_fire) begin
      v2_d = 1'b0;
    end

    if (out_fire) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v1_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      v2_q  <= 1'b0;
      y_q   <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      v2_q  <= v2_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  assign OUT_VALID = v2_q;
  assign Y         = y_q;
  assign OP_CNT    = cnt_q;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero_q, ones_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      zero_q <= 1'b0;
      ones_q <= 1'b0;
    end else if (adv2) begin
      zero_q <= (result == '0);
      ones_q <= (result == '1);
    end
  end

  assign ZERO = zero_q;
  assign ONES = ones_q;
`endif

endmodule
